// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST controller: FSM states and the
// per-element description (sweep direction, op pattern, data polarity).
package mbist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
  typedef enum logic [1:0] {DIR_ANY, DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic [1:0] {OPS_W, OPS_R, OPS_RW} ops_e;

  // pol is the data polarity of the first op; the write in an RW pair uses ~pol
  typedef struct packed {
    dir_e dir;
    ops_e ops;
    logic pol;
  } elem_t;

  localparam int N_ELEMS = 6;
  localparam int ELEM_W  = 3;

  function automatic elem_t elem_info(input logic [ELEM_W-1:0] idx);
    case (idx)
      3'd0:    elem_info = '{DIR_ANY,  OPS_W,  1'b0};
      3'd1:    elem_info = '{DIR_UP,   OPS_RW, 1'b0};
      3'd2:    elem_info = '{DIR_UP,   OPS_RW, 1'b1};
      3'd3:    elem_info = '{DIR_DOWN, OPS_RW, 1'b0};
      3'd4:    elem_info = '{DIR_DOWN, OPS_RW, 1'b1};
      default: elem_info = '{DIR_ANY,  OPS_R,  1'b0};
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March sweep; end of element is found by
// comparing against the sweep limit, never by wrap-around.
module mbist_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_down,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_at_limit
);

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(CAPACITY);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_down <= i_down;
      r_addr <= i_down ? LIMIT : '0;
    end else if (i_step) begin
      r_addr <= r_down ? r_addr - 1'b1 : r_addr + 1'b1;
    end
  end

  assign o_addr     = r_addr;
  assign o_at_limit = r_down ? (r_addr == '0) : (r_addr == LIMIT);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: issues one op per cycle, compares reads
// two cycles after their address, and records first-fail info and a count.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_mask,
  output logic [7:0]            fail_count
);

  state_e              r_state;
  logic [ELEM_W-1:0]   r_elem;
  logic                r_phase;
  logic [1:0]          r_drain_cnt;
  logic                r_busy, r_done;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_at_limit;
  ops_e                  w_ops;
  logic                  w_pol, w_next_down;
  logic                  w_issue, w_accept, w_op_rd, w_data_one;
  logic                  w_addr_last, w_elem_end, w_last_op;

  assign w_ops       = elem_info(r_elem).ops;
  assign w_pol       = elem_info(r_elem).pol;
  assign w_next_down = (elem_info(r_elem + 1'b1).dir == DIR_DOWN);

  assign w_issue     = (r_state == ST_RUN);
  assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_op_rd     = (w_ops == OPS_R) || (w_ops == OPS_RW && !r_phase);
  assign w_data_one  = r_phase ? ~w_pol : w_pol;
  assign w_addr_last = (w_ops != OPS_RW) || r_phase;
  assign w_elem_end  = w_issue && w_addr_last && w_at_limit;
  assign w_last_op   = w_elem_end && (r_elem == ELEM_W'(N_ELEMS - 1));

  mbist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CAPACITY   (CAPACITY)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept || (w_elem_end && !w_last_op)),
    .i_down     (!w_accept && w_next_down),
    .i_step     (w_issue && w_addr_last && !w_at_limit),
    .o_addr     (w_addr),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_elem      <= '0;
      r_phase     <= 1'b0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_RUN) || (r_state == ST_DRAIN);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_elem  <= '0;
            r_phase <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_done  <= (r_state == ST_DONE);
          end
        end
        ST_RUN: begin
          if (w_addr_last) begin
            r_phase <= 1'b0;
            if (w_last_op) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= '0;
            end else if (w_elem_end) begin
              r_elem <= r_elem + 1'b1;
            end
          end else begin
            r_phase <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 2'd2) r_state <= ST_DONE;
          else                     r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue (p0): wdata out, p1: write_read/address out, p2/p3: wait for rdata
  logic                  r_vld_p0, r_wr_p0;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write_read;
  logic [ADDR_WIDTH-1:0] r_address;
  logic                  r_rd_vld_p1, r_rd_vld_p2, r_rd_vld_p3;
  logic [ADDR_WIDTH-1:0] r_addr_p0, r_addr_p2, r_addr_p3;
  logic [DATA_WIDTH-1:0] r_exp_p0, r_exp_p1, r_exp_p2, r_exp_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0     <= 1'b0;
      r_wr_p0      <= 1'b0;
      r_wdata      <= '0;
      r_write_read <= 1'b0;
      r_address    <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_vld_p2  <= 1'b0;
      r_rd_vld_p3  <= 1'b0;
    end else begin
      r_vld_p0     <= w_issue;
      r_wr_p0      <= w_issue && !w_op_rd;
      r_wdata      <= (w_issue && !w_op_rd && w_data_one) ? '1 : '0;
      r_write_read <= r_vld_p0 && r_wr_p0;
      r_address    <= r_vld_p0 ? r_addr_p0 : '0;
      r_rd_vld_p1  <= r_vld_p0 && !r_wr_p0;
      r_rd_vld_p2  <= r_rd_vld_p1;
      r_rd_vld_p3  <= r_rd_vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    r_addr_p0 <= w_addr;
    r_exp_p0  <= w_data_one ? '1 : '0;
    r_exp_p1  <= r_exp_p0;
    r_exp_p2  <= r_exp_p1;
    r_addr_p2 <= r_address;
    r_exp_p3  <= r_exp_p2;
    r_addr_p3 <= r_addr_p2;
  end

  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_mismatch;
  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_mask;
  logic [7:0]            r_fail_count;

  assign w_mask     = rdata ^ r_exp_p3;
  assign w_mismatch = r_rd_vld_p3 && (w_mask != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail       <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_mask  <= '0;
      r_fail_count <= '0;
    end else if (w_accept) begin
      r_fail       <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_mask  <= '0;
      r_fail_count <= '0;
    end else if (w_mismatch) begin
      if (!r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_addr_p3;
        r_fail_mask <= w_mask;
      end
      if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 1'b1;
    end
  end

  assign write_read = r_write_read;
  assign address    = r_address;
  assign wdata      = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fail       = r_fail;
  assign fail_addr  = r_fail_addr;
  assign fail_mask  = r_fail_mask;
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural March C- model, a 2-cycle-latency
// memory with an optional stuck-at cell, directed and randomized runs.
module tb_mbist_march_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int N    = 16;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_mask;
  logic [7:0]    fail_count;

  int tests = 0;
  int fails = 0;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(N-1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .write_read (write_read),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_mask  (fail_mask),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Memory: write data arrives one cycle before its address; reads return 2 cycles later
  int            f_addr = -1;
  logic [DW-1:0] f_sa0 = '0, f_sa1 = '0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wdata_d = '0, rd_p1 = '0;
  logic [AW-1:0] rd_a_p1 = '0;

  always @(posedge clk) begin
    wdata_d <= wdata;
    if (write_read) mem[address] <= wdata_d;
    rd_p1   <= mem[address];
    rd_a_p1 <= address;
    rdata   <= (int'(rd_a_p1) == f_addr) ? ((rd_p1 & ~f_sa0) | f_sa1) : rd_p1;
  end

  typedef struct {
    bit            wr;
    int            addr;
    logic [DW-1:0] data;
  } op_t;

  op_t           ops[$];
  bit            m_fail;
  int            m_faddr, m_count;
  logic [DW-1:0] m_fmask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // March C- from its textual definition: per element, read value (-1 none), write value (-1 none)
  task automatic build_model();
    int rdv[6] = '{-1, 0, 1, 0, 1, 0};
    int wrv[6] = '{0, 1, 0, 1, 0, -1};
    logic [DW-1:0] m [N];
    logic [DW-1:0] got, expv;
    int a;
    ops.delete();
    m_fail = 0; m_faddr = 0; m_count = 0; m_fmask = '0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (rdv[e] >= 0) begin
          expv = (rdv[e] == 1) ? 8'hFF : 8'h00;
          ops.push_back('{0, a, expv});
          got = (a == f_addr) ? ((m[a] & ~f_sa0) | f_sa1) : m[a];
          if (got != expv) begin
            if (!m_fail) begin m_fail = 1; m_faddr = a; m_fmask = got ^ expv; end
            if (m_count < 255) m_count++;
          end
        end
        if (wrv[e] >= 0) begin
          m[a] = (wrv[e] == 1) ? 8'hFF : 8'h00;
          ops.push_back('{1, a, m[a]});
        end
      end
    end
  endtask

  // Pulse start so it is sampled at edge 0, then check every cycle through NOPS+4
  task automatic run_test(input string tag, input int fa, input logic [DW-1:0] sa0,
                          input logic [DW-1:0] sa1, input int extra_start);
    f_addr = fa; f_sa0 = sa0; f_sa1 = sa1;
    build_model();
    check({tag, "_nops"}, ops.size(), NOPS);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= NOPS + 4; c++) begin
      @(negedge clk);
      start = (c == extra_start);
      if (busy !== (c <= NOPS + 3)) check({tag, "_busy"}, busy, c <= NOPS + 3);
      if (done !== (c >= NOPS + 4)) check({tag, "_done"}, done, c >= NOPS + 4);
      if (c <= NOPS && ops[c-1].wr && wdata !== ops[c-1].data)
        check({tag, "_wdata"}, wdata, ops[c-1].data);
      if (c > NOPS + 1 && wdata !== '0) check({tag, "_wdata_idle"}, wdata, 0);
      if (c >= 2 && c <= NOPS + 1) begin
        if (write_read !== ops[c-2].wr) check({tag, "_wr"}, write_read, ops[c-2].wr);
        if (int'(address) !== ops[c-2].addr) check({tag, "_addr"}, address, ops[c-2].addr);
      end else if (c > NOPS + 1) begin
        if (write_read !== 1'b0 || address !== '0) check({tag, "_idle_bus"}, {write_read, address}, 0);
      end
    end
    start = 1'b0;
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done_end"}, done, 1);
    check({tag, "_fail"}, fail, m_fail);
    check({tag, "_fail_count"}, fail_count, m_count);
    if (m_fail) begin
      check({tag, "_fail_addr"}, fail_addr, m_faddr);
      check({tag, "_fail_mask"}, fail_mask, m_fmask);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_bus", {write_read, address, wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run; spot-check the opening ops and a stray start at cycle 50
    f_addr = -1; f_sa0 = '0; f_sa1 = '0;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); check("c1_wdata", wdata, 8'h00); check("c1_busy", busy, 1);
    check("c1_wr", write_read, 0);
    @(negedge clk); check("c2_wr", write_read, 1); check("c2_addr", address, 0);
    @(negedge clk); check("c3_wr", write_read, 1); check("c3_addr", address, 1);
    repeat (NOPS + 1) @(negedge clk);
    check("first_done", done, 1);

    run_test("clean", -1, 8'h00, 8'h00, 50);
    check("clean_cnt_const", fail_count, 0);

    run_test("sa1_b3_a9", 9, 8'h00, 8'h08, 0);
    check("sa1_addr_const", fail_addr, 9);
    check("sa1_mask_const", fail_mask, 8'h08);
    check("sa1_cnt_const", fail_count, 3);

    run_test("sa0_b0_a0", 0, 8'h01, 8'h00, 0);
    check("sa0a0_addr_const", fail_addr, 0);
    check("sa0a0_cnt_const", fail_count, 2);

    run_test("sa0_b0_a15", 15, 8'h01, 8'h00, 0);
    check("sa0a15_addr_const", fail_addr, 15);
    check("sa0a15_mask_const", fail_mask, 8'h01);
    check("sa0a15_cnt_const", fail_count, 2);

    for (int r = 0; r < 4; r++) begin
      int            fa;
      logic [DW-1:0] bm;
      fa = $urandom_range(0, N - 1);
      bm = 8'h01 << $urandom_range(0, DW - 1);
      if ($urandom_range(0, 1) == 1) run_test("rand_sa1", fa, 8'h00, bm, $urandom_range(5, NOPS));
      else                           run_test("rand_sa0", fa, bm, 8'h00, $urandom_range(5, NOPS));
    end

    // Reset at cycle 80 of a faulty run abandons it cleanly
    f_addr = 9; f_sa0 = '0; f_sa1 = 8'h08;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_fail", {fail, fail_addr, fail_mask, fail_count}, 0);
    check("mid_rst_bus", {write_read, address, wdata}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_fail", fail, 0);
    check("post_rst_cnt", fail_count, 0);
    check("post_rst_bus", {write_read, address, wdata}, 0);

    run_test("after_rst", $urandom_range(0, N - 1), 8'h00, 8'h80, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
